// File: rtl/idu_scoreboard_stage.sv
// Decode/issue stage with a per-register pending-write scoreboard.
// Holds one IFU payload, reads operands from the external regfile, stalls on
// RAW hazards (with a writeback bypass) and WAW counter saturation, and issues
// to EXU. Illegal opcodes are flagged on the issue bus rather than trapped here.
module idu_scoreboard_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [2*DATA_WIDTH-1:0]               ifu_to_idu_bus,
    input  logic                                  ifu_to_idu_valid,
    output logic                                  idu_allowin,
    output logic [REG_WIDTH-1:0]                  rf_raddr1,
    output logic [REG_WIDTH-1:0]                  rf_raddr2,
    input  logic [DATA_WIDTH-1:0]                 rf_rdata1,
    input  logic [DATA_WIDTH-1:0]                 rf_rdata2,
    input  logic                                  wb_en,
    input  logic [REG_WIDTH-1:0]                  wb_rd,
    input  logic [DATA_WIDTH-1:0]                 wb_data,
    input  logic                                  flush,
    output logic                                  idu_to_exu_valid,
    input  logic                                  exu_allowin,
    output logic [4*DATA_WIDTH+REG_WIDTH+1:0]     idu_to_exu_bus,
    output logic                                  stall_o
);

    localparam int NR_REGS = 2 ** REG_WIDTH;
    localparam int CNT_W   = $clog2(MAX_INFLIGHT + 1);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic                      idu_valid_q, idu_valid_d;
    logic [2*DATA_WIDTH-1:0]   payload_q, payload_d;
    logic [CNT_W-1:0]          cnt_q [NR_REGS];
    logic [CNT_W-1:0]          cnt_d [NR_REGS];

    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     inst;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [REG_WIDTH-1:0]      rd;
    logic [REG_WIDTH-1:0]      rs1;
    logic [REG_WIDTH-1:0]      rs2;

    logic                      illegal;
    logic                      writes_rd;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      rd_wen;

    logic                      byp_rs1, byp_rs2;
    logic                      hazard_rs1, hazard_rs2;
    logic                      sat;
    logic                      ready_go;
    logic                      issue_fire;
    logic [DATA_WIDTH-1:0]     src1, src2;
    logic [NR_REGS-1:0]        inc_vec, dec_vec;

    assign pc     = payload_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign inst   = payload_q[DATA_WIDTH-1:0];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rd     = inst[7 +: REG_WIDTH];
    assign rs1    = inst[15 +: REG_WIDTH];
    assign rs2    = inst[20 +: REG_WIDTH];

    // Classify the held instruction into legality, destination write and source use.
    always_comb begin
        illegal   = 1'b0;
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writes_rd = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_SYSTEM: begin
                writes_rd = (funct3 != 3'd0);
                uses_rs1  = (funct3 != 3'd0);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign rd_wen = writes_rd && (rd != '0) && !illegal;

    // A source waits while it has pending writes, unless the last one retires now.
    always_comb begin
        byp_rs1    = wb_en && (wb_rd == rs1) && (cnt_q[rs1] == CNT_W'(1));
        byp_rs2    = wb_en && (wb_rd == rs2) && (cnt_q[rs2] == CNT_W'(1));
        hazard_rs1 = uses_rs1 && (rs1 != '0) && (cnt_q[rs1] != '0) && !byp_rs1;
        hazard_rs2 = uses_rs2 && (rs2 != '0) && (cnt_q[rs2] != '0) && !byp_rs2;
        sat        = rd_wen && (cnt_q[rd] == CNT_W'(MAX_INFLIGHT));
        src1       = byp_rs1 ? wb_data : rf_rdata1;
        src2       = byp_rs2 ? wb_data : rf_rdata2;
    end

    assign ready_go         = !(hazard_rs1 || hazard_rs2 || sat);
    assign idu_allowin      = !idu_valid_q || (ready_go && exu_allowin);
    assign idu_to_exu_valid = idu_valid_q && ready_go && !flush;
    assign issue_fire       = idu_to_exu_valid && exu_allowin;
    assign stall_o          = idu_valid_q && !ready_go;
    assign rf_raddr1        = rs1;
    assign rf_raddr2        = rs2;
    assign idu_to_exu_bus   = {pc, inst, src1, src2, rd, rd_wen, illegal};

    // Flush kills the held slot; otherwise a free slot takes the IFU payload.
    always_comb begin
        idu_valid_d = idu_valid_q;
        payload_d   = payload_q;
        if (idu_allowin) begin
            idu_valid_d = ifu_to_idu_valid;
            payload_d   = ifu_to_idu_bus;
        end
        if (flush) begin
            idu_valid_d = 1'b0;
        end
    end

    // Issue adds a pending write, writeback retires one; both together cancel.
    always_comb begin
        inc_vec = (issue_fire && rd_wen) ? (NR_REGS'(1) << rd) : '0;
        dec_vec = (wb_en && (wb_rd != '0)) ? (NR_REGS'(1) << wb_rd) : '0;
        for (int i = 0; i < NR_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            idu_valid_q <= 1'b0;
            payload_q   <= '0;
            for (int i = 0; i < NR_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            idu_valid_q <= idu_valid_d;
            payload_q   <= payload_d;
            for (int i = 0; i < NR_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_idu_scoreboard_stage.sv
// Self-checking bench for idu_scoreboard_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural reference model.
module tb_idu_scoreboard_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int BW = 4*DW + RW + 2;

    logic              clock;
    logic              reset;
    logic [2*DW-1:0]   ifu_to_idu_bus;
    logic              ifu_to_idu_valid;
    logic              idu_allowin;
    logic [RW-1:0]     rf_raddr1, rf_raddr2;
    logic [DW-1:0]     rf_rdata1, rf_rdata2;
    logic              wb_en;
    logic [RW-1:0]     wb_rd;
    logic [DW-1:0]     wb_data;
    logic              flush;
    logic              idu_to_exu_valid;
    logic              exu_allowin;
    logic [BW-1:0]     idu_to_exu_bus;
    logic              stall_o;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_valid;
    logic [31:0] m_pc, m_inst;
    int          m_cnt [32];

    // Expectations of the current cycle, consumed by the model update
    bit          e_allowin, e_exu_valid, e_rdw;
    int          e_rd;

    idu_scoreboard_stage #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .MAX_INFLIGHT(3)) dut (
        .clock(clock), .reset(reset),
        .ifu_to_idu_bus(ifu_to_idu_bus), .ifu_to_idu_valid(ifu_to_idu_valid),
        .idu_allowin(idu_allowin),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .idu_to_exu_valid(idu_to_exu_valid), .exu_allowin(exu_allowin),
        .idu_to_exu_bus(idu_to_exu_bus), .stall_o(stall_o)
    );

    // Regfile stand-in: fixed per-index pattern, x0 reads as zero.
    function automatic logic [31:0] rf_val(input logic [4:0] i);
        if (i == 5'd0) return 32'h0;
        return {8'hA5, 3'd0, i, 8'h5A, 3'd0, i};
    endfunction

    assign rf_rdata1 = rf_val(rf_raddr1);
    assign rf_rdata2 = rf_val(rf_raddr2);

    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ifv, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic wbe, input logic [4:0] wbr,
                                 input logic [31:0] wbd, input logic fl, input logic ea);
        reset            = rst;
        ifu_to_idu_valid = ifv;
        ifu_to_idu_bus   = {pc, inst};
        wb_en            = wbe;
        wb_rd            = wbr;
        wb_data          = wbd;
        flush            = fl;
        exu_allowin      = ea;
        #1;
    endtask

    // Predict this cycle's outputs from the architectural rules and compare.
    task automatic checkOutput();
        logic [6:0]  op;
        logic [2:0]  f3;
        int          rs1, rs2, rd;
        bit          legal, writes, use1, use2, rdw, byp1, byp2, haz1, haz2, sat, rg;
        logic [31:0] s1, s2;
        logic [BW-1:0] exp_bus;
        if (!m_known) return;
        op  = m_inst[6:0];
        f3  = m_inst[14:12];
        rd  = int'(m_inst[11:7]);
        rs1 = int'(m_inst[19:15]);
        rs2 = int'(m_inst[24:20]);
        legal  = op inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73};
        writes = (op inside {7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03})
                 || (op == 7'h73 && f3 != 3'd0);
        use1   = legal && !(op inside {7'h37, 7'h17, 7'h6F}) && !(op == 7'h73 && f3 == 3'd0);
        use2   = op inside {7'h33, 7'h63, 7'h23};
        rdw    = writes && rd != 0 && legal;
        byp1   = wb_en && int'(wb_rd) == rs1 && m_cnt[rs1] == 1;
        byp2   = wb_en && int'(wb_rd) == rs2 && m_cnt[rs2] == 1;
        haz1   = use1 && rs1 != 0 && m_cnt[rs1] != 0 && !byp1;
        haz2   = use2 && rs2 != 0 && m_cnt[rs2] != 0 && !byp2;
        sat    = rdw && m_cnt[rd] == 3;
        rg     = !(haz1 || haz2 || sat);
        s1     = byp1 ? wb_data : rf_val(5'(rs1));
        s2     = byp2 ? wb_data : rf_val(5'(rs2));
        e_allowin   = !m_valid || (rg && exu_allowin);
        e_exu_valid = m_valid && rg && !flush;
        e_rdw       = rdw;
        e_rd        = rd;
        exp_bus     = {m_pc, m_inst, s1, s2, 5'(rd), rdw, !legal};
        checkVal("allowin", idu_allowin, e_allowin);
        checkVal("exu_valid", idu_to_exu_valid, e_exu_valid);
        checkVal("stall", stall_o, m_valid && !rg);
        checkVal("raddr1", rf_raddr1, rs1);
        checkVal("raddr2", rf_raddr2, rs2);
        if (e_exu_valid) checkVal("issue_bus", idu_to_exu_bus, exp_bus);
    endtask

    // Advance the reference model by one clock using this cycle's inputs.
    task automatic modelStep();
        int inc_r, dec_r;
        if (reset) begin
            m_known = 1;
            m_valid = 0;
            m_pc    = 0;
            m_inst  = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        inc_r = (e_exu_valid && exu_allowin && e_rdw) ? e_rd : -1;
        dec_r = (wb_en && wb_rd != 0) ? int'(wb_rd) : -1;
        if (!(inc_r >= 0 && inc_r == dec_r)) begin
            if (inc_r >= 0) m_cnt[inc_r]++;
            if (dec_r >= 0 && m_cnt[dec_r] > 0) m_cnt[dec_r]--;
        end
        if (e_allowin) begin
            m_valid = ifu_to_idu_valid;
            {m_pc, m_inst} = ifu_to_idu_bus;
        end
        if (flush) m_valid = 0;
    endtask

    task automatic step();
        checkOutput();
        modelStep();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] randInst();
        logic [6:0] op;
        case ($urandom_range(0, 11))
            0: op = 7'h13;  1: op = 7'h33;  2: op = 7'h37;  3: op = 7'h17;
            4: op = 7'h6F;  5: op = 7'h67;  6: op = 7'h63;  7: op = 7'h03;
            8: op = 7'h23;  9: op = 7'h73; 10: op = 7'h7F; default: op = 7'h0B;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
    localparam logic [31:0] ADD_X2_X1   = 32'h00108133;
    localparam logic [31:0] ADDI_X3_1   = 32'h00100193;
    localparam logic [31:0] ILLEGAL_7F  = 32'h0000007F;
    localparam logic [31:0] ADDI_X0_1   = 32'h00100013;
    localparam logic [31:0] ADDI_X5_3   = 32'h00300293;
    localparam logic [31:0] LUI_X4_1    = 32'h00001237;

    initial begin
        clock = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        // Reset cycle
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Reset state, then accept addi x1
        applyStimulus(0, 1, 32'h100, ADDI_X1_5, 0, 0, 0, 0, 1);
        checkVal("rst_allowin", idu_allowin, 1);
        checkVal("rst_exu_valid", idu_to_exu_valid, 0);
        checkVal("rst_stall", stall_o, 0);
        step();
        // addi x1 issues one cycle after accept; add x2 accepted
        applyStimulus(0, 1, 32'h104, ADD_X2_X1, 0, 0, 0, 0, 1);
        checkVal("addi_issue", idu_to_exu_valid, 1);
        checkVal("addi_rd", idu_to_exu_bus[6:2], 1);
        checkVal("addi_rdwen", idu_to_exu_bus[1], 1);
        checkVal("addi_src1", idu_to_exu_bus[70:39], 0);
        step();
        // RAW on x1 with nothing retiring
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkVal("raw_stall", stall_o, 1);
        checkVal("raw_valid", idu_to_exu_valid, 0);
        step();
        // Writeback of x1 bypasses into the stalled add
        applyStimulus(0, 0, 0, 0, 1, 5'd1, 32'd5, 0, 1);
        checkVal("byp_issue", idu_to_exu_valid, 1);
        checkVal("byp_src1", idu_to_exu_bus[70:39], 5);
        checkVal("byp_src2", idu_to_exu_bus[38:7], 5);
        checkVal("byp_stall", stall_o, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 5'd2, 32'd7, 0, 1);
        step();

        // WAW saturation on x3
        applyStimulus(0, 1, 32'h200, ADDI_X3_1, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 1, 32'h204, ADDI_X3_1, 0, 0, 0, 0, 1);
        checkVal("w1_issue", idu_to_exu_valid, 1);
        step();
        applyStimulus(0, 1, 32'h208, ADDI_X3_1, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 1, 32'h20C, ADDI_X3_1, 0, 0, 0, 0, 1);
        checkVal("w3_issue", idu_to_exu_valid, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkVal("sat_stall", stall_o, 1);
        checkVal("sat_valid", idu_to_exu_valid, 0);
        step();
        // Retire one: counter still saturated this cycle, issue next cycle
        applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 1);
        checkVal("sat_wb_stall", stall_o, 1);
        step();
        applyStimulus(0, 1, 32'h210, ILLEGAL_7F, 0, 0, 0, 0, 1);
        checkVal("w4_issue", idu_to_exu_valid, 1);
        step();
        // Illegal instruction issues with the flag and no destination write
        applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 1);
        checkVal("ill_issue", idu_to_exu_valid, 1);
        checkVal("ill_flag", idu_to_exu_bus[0], 1);
        checkVal("ill_rdwen", idu_to_exu_bus[1], 0);
        checkVal("ill_stall", stall_o, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 1);
        step();
        applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 1);
        step();

        // Flush of a stalled instruction
        applyStimulus(0, 1, 32'h300, ADDI_X1_5, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 1, 32'h304, ADD_X2_X1, 0, 0, 0, 0, 1);
        step();
        applyStimulus(0, 1, 32'h308, ADDI_X5_3, 0, 0, 0, 1, 1);
        checkVal("flush_valid", idu_to_exu_valid, 0);
        checkVal("flush_stall", stall_o, 1);
        step();
        applyStimulus(0, 1, 32'h30C, ADD_X2_X1, 0, 0, 0, 0, 1);
        checkVal("post_flush_valid", idu_to_exu_valid, 0);
        checkVal("post_flush_stall", stall_o, 0);
        checkVal("post_flush_allowin", idu_allowin, 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkVal("cnt_kept_stall", stall_o, 1);
        step();
        applyStimulus(0, 0, 0, 0, 1, 5'd1, 32'd9, 0, 1);
        checkVal("flush_wb_issue", idu_to_exu_valid, 1);
        checkVal("flush_wb_src1", idu_to_exu_bus[70:39], 9);
        step();

        // x0 destination and x0 sources
        applyStimulus(0, 1, 32'h400, ADDI_X0_1, 1, 5'd2, 32'd1, 0, 1);
        step();
        applyStimulus(0, 1, 32'h404, ADDI_X5_3, 1, 5'd0, 32'd1, 0, 1);
        checkVal("x0_issue", idu_to_exu_valid, 1);
        checkVal("x0_rdwen", idu_to_exu_bus[1], 0);
        step();
        applyStimulus(0, 1, 32'h408, LUI_X4_1, 0, 0, 0, 0, 1);
        checkVal("rs1x0_issue", idu_to_exu_valid, 1);
        checkVal("rs1x0_stall", stall_o, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkVal("lui_issue", idu_to_exu_valid, 1);
        step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            applyStimulus(c == 2000,
                          $urandom_range(0, 9) < 7,
                          $urandom & 32'hFFFF_FFFC,
                          randInst(),
                          $urandom_range(0, 9) < 4,
                          5'($urandom_range(0, 3)),
                          $urandom,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idu_scoreboard_stage.md
Name: idu_scoreboard_stage

Overview:
- Parametrised decode/issue stage that replaces the single-cycle IDU's unconditional ready_go with a per-register pending-write scoreboard.
- Registers the IFU payload under a valid/allowin handshake and reads operands from an external regfile.
- Stalls on RAW hazards, with a writeback bypass, and issues to EXU.
- Supports redirect flush, and flags illegal instructions instead of halting simulation.

Parameters:
- DATA_WIDTH, 32, width of pc, inst, data.
- REG_WIDTH, 5, register index width; NR_REGS = 2**REG_WIDTH (4 gives RV32E).
- MAX_INFLIGHT, 3, maximum outstanding writes per register; counter width CNT_W = clog2(MAX_INFLIGHT+1).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- ifu_to_idu_bus  in  2*DATA_WIDTH  {pc, inst}
- ifu_to_idu_valid  in  1  IFU payload valid
- idu_allowin  out  1  stage can accept
- rf_raddr1  out  REG_WIDTH  rs1 of held inst
- rf_raddr2  out  REG_WIDTH  rs2 of held inst
- rf_rdata1  in  DATA_WIDTH  regfile read data 1
- rf_rdata2  in  DATA_WIDTH  regfile read data 2
- wb_en  in  1  writeback retiring this cycle
- wb_rd  in  REG_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback value
- flush  in  1  branch/trap redirect; kill held inst
- idu_to_exu_valid  out  1  issue valid
- exu_allowin  in  1  EXU accepts
- idu_to_exu_bus  out  4*DATA_WIDTH+REG_WIDTH+2  {pc, inst, src1, src2, rd, rd_wen, illegal}
- stall_o  out  1  hazard stall this cycle (perf counter)

Behaviour:
- Reset:
  - idu_valid=0, payload register=0, all scoreboard counters=0.
  - idu_to_exu_valid=0, stall_o=0, idu_allowin=1.
- Handshake:
  - idu_allowin = !idu_valid | (ready_go & exu_allowin).
  - On allowin, idu_valid <= ifu_to_idu_valid & !flush and payload <= bus.
  - idu_to_exu_valid = idu_valid & ready_go & !flush.
- Decode classes (opcode):
  - writes_rd: OP-IMM, OP, LUI, AUIPC, JAL, JALR, LOAD, SYSTEM with funct3!=0.
  - uses_rs1: all valid classes except LUI, AUIPC, JAL, ecall/ebreak/mret.
  - uses_rs2: OP, BRANCH, STORE.
  - rd_wen = writes_rd & (rd!=0) & !illegal.
  - illegal = opcode not in {OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM}. Illegal insts issue normally with rd_wen=0 and uses_rs1=uses_rs2=0; there is no $fatal.
- Hazard, per source s in {rs1, rs2}:
  - busy_s = uses_s & (s!=0) & cnt[s]!=0.
  - byp_s = wb_en & (wb_rd==s) & cnt[s]==1. The operand is then wb_data, and the source is not stalled.
  - hazard_s = busy_s & !byp_s.
- WAW saturation: sat = rd_wen & cnt[rd]==MAX_INFLIGHT.
- ready_go = !(hazard_rs1 | hazard_rs2 | sat); stall_o = idu_valid & !ready_go.
- Operands: src1/src2 = bypass ? wb_data : rf_rdata. src1/src2 are raw register values; immediate/pc selection is EXU's job in this generation.
- Scoreboard, every cycle:
  - inc = issue fire (idu_to_exu_valid & exu_allowin) & rd_wen, applied to cnt[rd].
  - dec = wb_en & wb_rd!=0, applied to cnt[wb_rd].
  - Same register inc & dec in one cycle: the counter is unchanged.
  - Decrement at 0 never occurs legally; if it does, the counter holds 0.
  - x0 is never counted.
- Flush:
  - Kills the held inst the same cycle (no issue, no inc); idu_valid=0 next cycle.
  - A concurrent ifu_to_idu_valid is dropped.
  - Scoreboard untouched: already-issued writes still retire.
- Reset mid-operation: all state cleared regardless of wb_en/flush.
- Latency: 1 cycle IFU-accept to issue when hazard-free; stall length = cycles until the last pending write retires.

Test Plan:
- Reset, then addi x1,x0,5 with exu_allowin=1 → issue 1 cycle after accept, rd=1, rd_wen=1, cnt[1]=1.
- addi x1 issued; next add x2,x1,x1 with no wb → stall_o=1, valid=0. Then wb_en, wb_rd=1, wb_data=5 → same-cycle issue with src1=src2=5, cnt[1] 1→0 while cnt[2]→1.
- Issue 3 writes to x3 with no wb (MAX_INFLIGHT=3), 4th addi x3 → stalls on sat. One wb to x3 → 4th issues, cnt stays 3.
- Inst 0x0000007F (illegal opcode) → issued with illegal=1, rd_wen=0, no scoreboard change, no stall.
- Stalled add x2,x1,x1 plus flush=1 → idu_to_exu_valid=0, next cycle idu_valid=0, cnt[1] still 1 until wb.
- addi x0,x0,1 and wb_rd=0 → cnt[0] stays 0; lui x4 while cnt[0]... / rs1=x0 users never stall.
